piso_serial_tx: RTL



---
 rtl/piso_serial_tx.sv | 87 ++++++++
 1 files changed

// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1).
// All state advances on the falling edge of c_i; outputs decode registered state only.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line idle high, waiting for load_i
// ST_START | driving the start bit (0)
// ST_DATA  | driving shift register bit 0, one data bit per cycle
// ST_STOP  | driving the stop bit (1), done_o high; load_i here chains a frame
module piso_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic             c_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_STOP: begin
                if (load_i) begin
                    state_d = ST_START;
                    sreg_d  = din_i;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_DATA;
            ST_DATA: begin
                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge c_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sout_o = 1'b1;
        busy_o = 1'b1;
        done_o = 1'b0;
        case (state_q)
            ST_IDLE:  busy_o = 1'b0;
            ST_START: sout_o = 1'b0;
            ST_DATA:  sout_o = sreg_q[0];
            ST_STOP:  done_o = 1'b1;
            default:  busy_o = 1'b0;
        endcase
    end

endmodule
